// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default operand width and iteration counter width.
package alu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_seq_if.sv
// Request/result bundle between ALU control (master) and the sequential divider (slave).
interface divider_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op1, op2,
    input  res, rem, busy, done, div_by_zero
  );

  modport slave (
    input  start, op1, op2,
    output res, rem, busy, done, div_by_zero
  );

endinterface

// File: rtl/sub_step.sv
// One restoring-division step: N-bit trial subtraction p - d with a no-borrow (p >= d) flag.
module sub_step
  import alu_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] d,
  output logic [N-1:0] diff,
  output logic         ge
);

  logic borrow;

  assign {borrow, diff} = {1'b0, p} - {1'b0, d};
  assign ge             = ~borrow;

endmodule

// File: rtl/divider_seq.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations, results registered
// and presented with a one-cycle done pulse; divide-by-zero short-circuits straight to DONE.
module divider_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  divider_seq_if.slave bus
);

  localparam int CNT_BITS = $clog2(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(WIDTH - 1);

  div_state_t          state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [WIDTH:0]      p_q;
  logic [WIDTH-1:0]    q_q;
  logic [WIDTH-1:0]    d_q;
  logic [WIDTH-1:0]    res_q;
  logic [WIDTH-1:0]    rem_q;
  logic                busy_q;
  logic                done_q;
  logic                dbz_q;

  logic [WIDTH:0]      p_shift;
  logic [WIDTH:0]      diff;
  logic                ge;
  logic [WIDTH:0]      p_d;
  logic [WIDTH-1:0]    q_d;

  // The restored remainder is always below D, so its top bit is zero and drops out of the shift.
  assign p_shift = (WIDTH + 1)'({p_q, q_q[WIDTH-1]});

  sub_step #(.N(WIDTH + 1)) u_step (
    .p    (p_shift),
    .d    ({1'b0, d_q}),
    .diff (diff),
    .ge   (ge)
  );

  always_comb begin
    p_d = ge ? diff : p_shift;
    q_d = {q_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dbz_q <= 1'b0;
            cnt_q <= '0;
            p_q   <= '0;
            q_q   <= bus.op1;
            d_q   <= bus.op2;
            if (bus.op2 == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              res_q   <= '1;
              rem_q   <= bus.op1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          // Results are published only from the final step so partial quotients never leak out.
          if (cnt_q == LAST_ITER) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= q_d;
            rem_q   <= p_d[WIDTH-1:0];
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.res         = res_q;
  assign bus.rem         = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Randomised and directed checks of divider_seq against a plain-arithmetic reference model.
module tb_divider_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [W-1:0] last_res = '0;
  logic [W-1:0] last_rem = '0;

  divider_seq_if #(.WIDTH(W)) dif ();

  divider_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: quotient/remainder by ordinary arithmetic, latency in clock edges counted from the
  // accepting edge (inclusive) to the edge after which done is visible.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat, output int busy_cycles);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1; busy_cycles = 0;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = W + 1; busy_cycles = W;
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                         input bit disturb);
    logic [W-1:0] eq, er;
    logic         ez;
    int           elat, ebusy, edges, busy_cnt, extra;
    bit           seen;
    model(a, b, eq, er, ez, elat, ebusy);
    dif.start = 1'b1;
    dif.op1   = a;
    dif.op2   = b;
    edges = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) dif.start = 1'b0;
      if (disturb && edges == 5) begin
        dif.start = 1'b1; dif.op1 = 1; dif.op2 = 1;
      end
      if (disturb && edges == 6) dif.start = 1'b0;
      if (disturb && edges == 12) begin
        dif.op1 = $urandom; dif.op2 = $urandom;
      end
      if (b != 0 && edges == 10) chk({tag, ":res_hidden"}, dif.res, last_res);
      if (dif.done) seen = 1'b1;
      else if (dif.busy) busy_cnt++;
    end
    chk({tag, ":done_seen"}, seen, 1);
    chk({tag, ":latency"}, edges, elat);
    chk({tag, ":busy_cycles"}, busy_cnt, ebusy);
    chk({tag, ":busy_at_done"}, dif.busy, 0);
    chk({tag, ":res"}, dif.res, eq);
    chk({tag, ":rem"}, dif.rem, er);
    chk({tag, ":dbz"}, dif.div_by_zero, ez);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (dif.done) extra++;
    end
    chk({tag, ":single_done"}, extra, 0);
    chk({tag, ":res_held"}, dif.res, eq);
    chk({tag, ":dbz_held"}, dif.div_by_zero, ez);
    last_res = eq;
    last_rem = er;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         ez;
    int           elat, ebusy, first_done, second_done, ndone;

    dif.start = 1'b0;
    dif.op1   = '0;
    dif.op2   = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:res", dif.res, 0);
    chk("reset:rem", dif.rem, 0);
    chk("reset:busy", dif.busy, 0);
    chk("reset:done", dif.done, 0);
    chk("reset:dbz", dif.div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(32'd25, 32'd5, "t1_25_5", 1'b0);
    run_div(32'd999, 32'd25, "t2_999_25", 1'b0);
    run_div(32'd10, 32'd33, "t3_small", 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, "t3_div1", 1'b0);
    run_div(32'd15, 32'd0, "t4_dbz", 1'b0);
    run_div(32'd20, 32'd5, "t4_after_dbz", 1'b0);
    run_div(32'd33, 32'd11, "t5_ignore", 1'b1);

    // Reset in the middle of a division aborts it silently.
    dif.start = 1'b1; dif.op1 = 32'd999; dif.op2 = 32'd25;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 1) dif.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst:busy", dif.busy, 0);
    chk("t6_rst:res", dif.res, 0);
    chk("t6_rst:rem", dif.rem, 0);
    chk("t6_rst:done", dif.done, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dif.done) ndone++;
    end
    chk("t6_rst:no_done", ndone, 0);
    last_res = '0;
    last_rem = '0;
    run_div(32'd20, 32'd5, "t6_after_rst", 1'b0);

    // Start held high: consecutive acceptances spaced by the full iteration count plus two.
    a = $urandom; b = $urandom_range(1, 1000);
    model(a, b, eq, er, ez, elat, ebusy);
    dif.start = 1'b1; dif.op1 = a; dif.op2 = b;
    first_done = -1; second_done = -1;
    for (int e = 1; e <= 120 && second_done < 0; e++) begin
      @(posedge clk); #1;
      if (dif.done) begin
        chk("b2b:res", dif.res, eq);
        chk("b2b:rem", dif.rem, er);
        if (first_done < 0) first_done = e;
        else second_done = e;
      end
    end
    dif.start = 1'b0;
    chk("b2b:first_latency", first_done, W + 1);
    chk("b2b:period", second_done - first_done, W + 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    last_res = eq;
    last_rem = er;

    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = $urandom;
      case (sel)
        0:       b = '0;
        1:       b = 32'd1;
        2, 3:    b = $urandom_range(1, 255);
        4:       b = a + 32'd1 + $urandom_range(0, 100);
        default: b = $urandom;
      endcase
      run_div(a, b, $sformatf("rand%0d", n), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
